// File: rtl/branch_redirect_ctrl_if.sv
// Branch-resolution inputs, fetch redirect handshake and lane control outputs
// for branch_redirect_ctrl. The controller uses the slave side.
interface branch_redirect_ctrl_if #(
  parameter int XLEN = 32
);
  logic            mode;
  logic            br_validA;
  logic            branch_takenA;
  logic [XLEN-1:0] targetA;
  logic            br_validB;
  logic            branch_takenB;
  logic [XLEN-1:0] targetB;
  logic            redirect_valid;
  logic            redirect_lane;
  logic [XLEN-1:0] redirect_pc;
  logic            redirect_ready;
  logic            flushA;
  logic            flushB;
  logic            stallA;
  logic            stallB;
  logic            busy;

  modport slave (
    input  mode, br_validA, branch_takenA, targetA,
           br_validB, branch_takenB, targetB, redirect_ready,
    output redirect_valid, redirect_lane, redirect_pc,
           flushA, flushB, stallA, stallB, busy
  );

  modport master (
    output mode, br_validA, branch_takenA, targetA,
           br_validB, branch_takenB, targetB, redirect_ready,
    input  redirect_valid, redirect_lane, redirect_pc,
           flushA, flushB, stallA, stallB, busy
  );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Converts taken-branch decisions from one or two lanes into PC redirect
// requests on a single shared fetch redirect port, flushing and stalling the
// offending lane until its redirect is accepted and the pipe has drained.
//
// state | meaning
// IDLE  | no redirect in flight; picks a pending lane (fair on ties)
// REQ   | redirect_valid held with the selected lane's target until ready
// DRAIN | post-accept bubble; selected lane stays stalled
//
// DRAIN_CYCLES must be at least 1.
module branch_redirect_ctrl #(
  parameter int XLEN         = 32,
  parameter int DRAIN_CYCLES = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  branch_redirect_ctrl_if.slave bus
);
  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_sel_lane, w_sel_lane_nxt;
  logic            r_last_served, w_last_served_nxt;
  logic [CW-1:0]   r_drain_cnt, w_drain_cnt_nxt;
  logic            r_pendA, r_pendB;
  logic [XLEN-1:0] r_pc_regA, r_pc_regB;
  logic            r_flushA, r_flushB;
  logic            w_stallA, w_stallB;
  logic            w_capA, w_capB;
  logic            w_accept;
  logic            w_active;

  assign w_active = (r_state != S_IDLE);
  assign w_stallA = r_pendA | (w_active & ~r_sel_lane);
  assign w_stallB = r_pendB | (w_active &  r_sel_lane);
  // Lane B is ignored entirely in unified mode.
  assign w_capA   = bus.br_validA & bus.branch_takenA & ~w_stallA;
  assign w_capB   = ~bus.mode & bus.br_validB & bus.branch_takenB & ~w_stallB;
  assign w_accept = (r_state == S_REQ) & bus.redirect_ready;

  // Pending flags, captured targets and one-cycle flush pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pendA   <= 1'b0;
      r_pendB   <= 1'b0;
      r_pc_regA <= '0;
      r_pc_regB <= '0;
      r_flushA  <= 1'b0;
      r_flushB  <= 1'b0;
    end else begin
      r_flushA <= w_capA;
      r_flushB <= w_capB;
      if (w_capA) begin
        r_pendA   <= 1'b1;
        r_pc_regA <= bus.targetA;
      end else if (w_accept && !r_sel_lane) begin
        r_pendA <= 1'b0;
      end
      if (bus.mode) begin
        r_pendB <= 1'b0;
      end else if (w_capB) begin
        r_pendB   <= 1'b1;
        r_pc_regB <= bus.targetB;
      end else if (w_accept && r_sel_lane) begin
        r_pendB <= 1'b0;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_sel_lane    <= 1'b0;
      r_last_served <= 1'b1;
      r_drain_cnt   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_sel_lane    <= w_sel_lane_nxt;
      r_last_served <= w_last_served_nxt;
      r_drain_cnt   <= w_drain_cnt_nxt;
    end
  end

  // FSM next-state: lane selection, handshake and drain countdown.
  always_comb begin
    w_state_nxt       = r_state;
    w_sel_lane_nxt    = r_sel_lane;
    w_last_served_nxt = r_last_served;
    w_drain_cnt_nxt   = r_drain_cnt;
    case (r_state)
      S_IDLE: begin
        if (r_pendA || r_pendB) begin
          w_state_nxt = S_REQ;
          if (r_pendA && r_pendB) w_sel_lane_nxt = ~r_last_served;
          else                    w_sel_lane_nxt = r_pendB;
        end
      end
      S_REQ: begin
        if (bus.redirect_ready) begin
          w_state_nxt       = S_DRAIN;
          w_last_served_nxt = r_sel_lane;
          w_drain_cnt_nxt   = CW'(DRAIN_CYCLES - 1);
        end
      end
      S_DRAIN: begin
        if (r_drain_cnt == '0) w_state_nxt = S_IDLE;
        else                   w_drain_cnt_nxt = r_drain_cnt - 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.redirect_valid = (r_state == S_REQ);
  assign bus.redirect_lane  = bus.redirect_valid & r_sel_lane;
  assign bus.redirect_pc    = !bus.redirect_valid ? '0 :
                              (r_sel_lane ? r_pc_regB : r_pc_regA);
  assign bus.flushA         = r_flushA;
  assign bus.flushB         = r_flushB;
  assign bus.stallA         = w_stallA;
  assign bus.stallB         = w_stallB;
  assign bus.busy           = r_pendA | r_pendB | w_active;
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
module tb_branch_redirect_ctrl;
  localparam int XLEN  = 32;
  localparam int DRAIN = 2;

  typedef struct packed {
    logic            lane;
    logic [XLEN-1:0] pc;
  } redir_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fails;
  redir_t exp_q[$];

  branch_redirect_ctrl_if #(.XLEN(XLEN)) bus ();

  branch_redirect_ctrl #(.XLEN(XLEN), .DRAIN_CYCLES(DRAIN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every accepted redirect must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n && bus.redirect_valid && bus.redirect_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fails++;
        $display("FAIL sb_unexpected: got lane %0d pc %0h, required no redirect",
                 bus.redirect_lane, bus.redirect_pc);
      end else begin
        redir_t e;
        e = exp_q.pop_front();
        if ({bus.redirect_lane, bus.redirect_pc} !== {e.lane, e.pc}) begin
          n_fails++;
          $display("FAIL sb_redirect: got lane %0d pc %0h, required lane %0d pc %0h",
                   bus.redirect_lane, bus.redirect_pc, e.lane, e.pc);
        end
      end
    end
    if (rst_n && !bus.redirect_valid) begin
      n_checks++;
      if ({bus.redirect_lane, bus.redirect_pc} !== '0) begin
        n_fails++;
        $display("FAIL idle_zero: got lane %0d pc %0h, required 0",
                 bus.redirect_lane, bus.redirect_pc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.br_validA = 0; bus.branch_takenA = 0; bus.targetA = '0;
    bus.br_validB = 0; bus.branch_takenB = 0; bus.targetB = '0;
  endtask

  task automatic push_exp(input logic lane, input logic [XLEN-1:0] pc);
    redir_t e;
    e.lane = lane;
    e.pc   = pc;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 0;
    clear_inputs();
    bus.redirect_ready = 0;
    tick();
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (bus.busy && k < 40) begin
      tick();
      k++;
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fails++;
      $display("FAIL %s_idle_timeout: got busy %0b, required 0", name, bus.busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    bus.mode = 1;
    clear_inputs();
    bus.redirect_ready = 0;
    tick();
    tick();
    n_checks++;
    if ({bus.redirect_valid, bus.redirect_lane, bus.redirect_pc, bus.flushA, bus.flushB,
         bus.stallA, bus.stallB, bus.busy} !== '0) begin
      n_fails++;
      $display("FAIL reset_outputs: got v%0b l%0b pc%0h fa%0b fb%0b sa%0b sb%0b busy%0b, required all 0",
               bus.redirect_valid, bus.redirect_lane, bus.redirect_pc, bus.flushA,
               bus.flushB, bus.stallA, bus.stallB, bus.busy);
    end
    rst_n = 1;
    tick();
  endtask

  task automatic test_unified();
    bus.mode = 1;
    bus.redirect_ready = 1;
    bus.br_validA = 1; bus.branch_takenA = 1; bus.targetA = 32'h0000_1000;
    push_exp(1'b0, 32'h0000_1000);
    tick();                                   // capture edge T
    clear_inputs();
    n_checks++;
    if ({bus.flushA, bus.stallA, bus.redirect_valid} !== 3'b110) begin
      n_fails++;
      $display("FAIL uni_after_capture: got flush %0b stall %0b valid %0b, required 1 1 0",
               bus.flushA, bus.stallA, bus.redirect_valid);
    end
    tick();                                   // T+1
    n_checks++;
    if ({bus.redirect_valid, bus.redirect_lane, bus.redirect_pc, bus.flushA} !==
        {1'b1, 1'b0, 32'h0000_1000, 1'b0}) begin
      n_fails++;
      $display("FAIL uni_redirect: got v%0b l%0b pc %0h flush %0b, required v1 l0 pc 1000 flush 0",
               bus.redirect_valid, bus.redirect_lane, bus.redirect_pc, bus.flushA);
    end
    tick();                                   // T+2 accept edge
    n_checks++;
    if ({bus.redirect_valid, bus.stallA} !== 2'b01) begin
      n_fails++;
      $display("FAIL uni_drain1: got valid %0b stall %0b, required 0 1",
               bus.redirect_valid, bus.stallA);
    end
    tick();
    n_checks++;
    if (bus.stallA !== 1'b1) begin
      n_fails++;
      $display("FAIL uni_drain2: got stall %0b, required 1", bus.stallA);
    end
    tick();                                   // accept + 2
    n_checks++;
    if ({bus.stallA, bus.busy} !== 2'b00) begin
      n_fails++;
      $display("FAIL uni_release: got stall %0b busy %0b, required 0 0", bus.stallA, bus.busy);
    end
  endtask

  task automatic test_no_effect();
    bus.mode = 1;
    bus.redirect_ready = 1;
    for (int i = 0; i < 10; i++) begin
      bus.br_validA     = (i < 5);
      bus.branch_takenA = (i >= 5);
      bus.targetA       = 32'h0000_2000 + i;
      tick();
      n_checks++;
      if ({bus.flushA, bus.redirect_valid, bus.stallA, bus.busy} !== 4'b0) begin
        n_fails++;
        $display("FAIL no_effect_%0d: got flush %0b valid %0b stall %0b busy %0b, required 0",
                 i, bus.flushA, bus.redirect_valid, bus.stallA, bus.busy);
      end
    end
    clear_inputs();
  endtask

  task automatic test_split_tie();
    int ka, kb;
    do_reset();
    bus.mode = 0;
    bus.redirect_ready = 1;
    bus.br_validA = 1; bus.branch_takenA = 1; bus.targetA = 32'h100;
    bus.br_validB = 1; bus.branch_takenB = 1; bus.targetB = 32'h200;
    push_exp(1'b0, 32'h100);
    push_exp(1'b1, 32'h200);
    tick();                                   // T
    clear_inputs();
    n_checks++;
    if ({bus.flushA, bus.flushB} !== 2'b11) begin
      n_fails++;
      $display("FAIL split_flush: got flushA %0b flushB %0b, required 1 1", bus.flushA, bus.flushB);
    end
    ka = -1;
    kb = -1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (bus.redirect_valid && !bus.redirect_lane && ka < 0) ka = k;
      if (bus.redirect_valid &&  bus.redirect_lane && kb < 0) kb = k;
    end
    n_checks++;
    if (ka != 1 || kb != DRAIN + 3) begin
      n_fails++;
      $display("FAIL split_timing: got A at T+%0d B at T+%0d, required A at T+1 B at T+%0d",
               ka, kb, DRAIN + 3);
    end
    wait_idle("split1");
    // last_served is now B, so the next tie must go to A again.
    bus.br_validA = 1; bus.branch_takenA = 1; bus.targetA = 32'h300;
    bus.br_validB = 1; bus.branch_takenB = 1; bus.targetB = 32'h400;
    push_exp(1'b0, 32'h300);
    push_exp(1'b1, 32'h400);
    tick();
    clear_inputs();
    tick();
    n_checks++;
    if ({bus.redirect_valid, bus.redirect_lane} !== 2'b10) begin
      n_fails++;
      $display("FAIL split_fair: got valid %0b lane %0b, required valid 1 lane 0",
               bus.redirect_valid, bus.redirect_lane);
    end
    wait_idle("split2");
  endtask

  task automatic test_backpressure();
    int k;
    bus.mode = 0;
    bus.redirect_ready = 0;
    bus.br_validA = 1; bus.branch_takenA = 1; bus.targetA = 32'hA0A0;
    push_exp(1'b0, 32'hA0A0);
    tick();
    clear_inputs();
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        bus.br_validB = 1; bus.branch_takenB = 1; bus.targetB = 32'hB0B0;
        push_exp(1'b1, 32'hB0B0);
      end
      tick();
      clear_inputs();
      n_checks++;
      if ({bus.redirect_valid, bus.redirect_lane, bus.redirect_pc} !== {1'b1, 1'b0, 32'hA0A0}) begin
        n_fails++;
        $display("FAIL bp_hold_%0d: got v%0b l%0b pc %0h, required v1 l0 pc a0a0",
                 i, bus.redirect_valid, bus.redirect_lane, bus.redirect_pc);
      end
    end
    bus.redirect_ready = 1;
    tick();                                   // accept edge R
    n_checks++;
    if ({bus.redirect_valid, bus.stallB, bus.stallA} !== 3'b011) begin
      n_fails++;
      $display("FAIL bp_accept: got valid %0b stallB %0b stallA %0b, required 0 1 1",
               bus.redirect_valid, bus.stallB, bus.stallA);
    end
    k = 0;
    while (!bus.redirect_valid && k < 20) begin
      tick();
      k++;
    end
    n_checks++;
    if (k != DRAIN + 1 || bus.redirect_lane !== 1'b1 || bus.redirect_pc !== 32'hB0B0) begin
      n_fails++;
      $display("FAIL bp_queued_b: got R+%0d lane %0b pc %0h, required R+%0d lane 1 pc b0b0",
               k, bus.redirect_lane, bus.redirect_pc, DRAIN + 1);
    end
    wait_idle("bp");
  endtask

  task automatic test_unified_b();
    bus.mode = 1;
    bus.redirect_ready = 1;
    for (int i = 0; i < 10; i++) begin
      bus.br_validB     = 1;
      bus.branch_takenB = i[0];
      bus.targetB       = 32'h0000_3000 + i;
      if (i == 3) begin
        bus.br_validA = 1; bus.branch_takenA = 1; bus.targetA = 32'h900;
        push_exp(1'b0, 32'h900);
      end
      tick();
      bus.br_validA = 0;
      bus.branch_takenA = 0;
      n_checks++;
      if ({bus.flushB, bus.stallB, bus.redirect_valid & bus.redirect_lane} !== 3'b0) begin
        n_fails++;
        $display("FAIL uni_laneb_%0d: got flushB %0b stallB %0b lane1 %0b, required 0",
                 i, bus.flushB, bus.stallB, bus.redirect_valid & bus.redirect_lane);
      end
    end
    clear_inputs();
    wait_idle("unib");
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.mode = 0;
    bus.redirect_ready = 0;
    bus.br_validA = 1; bus.branch_takenA = 1; bus.targetA = 32'h5000;
    bus.br_validB = 1; bus.branch_takenB = 1; bus.targetB = 32'h6000;
    tick();
    clear_inputs();
    tick();
    n_checks++;
    if ({bus.redirect_valid, bus.stallB} !== 2'b11) begin
      n_fails++;
      $display("FAIL rstmid_req: got valid %0b stallB %0b, required 1 1",
               bus.redirect_valid, bus.stallB);
    end
    #2;
    rst_n = 0;
    #1;
    n_checks++;
    if ({bus.redirect_valid, bus.redirect_lane, bus.redirect_pc, bus.flushA, bus.flushB,
         bus.stallA, bus.stallB, bus.busy} !== '0) begin
      n_fails++;
      $display("FAIL rstmid_outputs: got v%0b pc %0h sa%0b sb%0b busy%0b, required all 0",
               bus.redirect_valid, bus.redirect_pc, bus.stallA, bus.stallB, bus.busy);
    end
    tick();
    rst_n = 1;
    bus.redirect_ready = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if ({bus.redirect_valid, bus.busy, bus.flushA, bus.flushB} !== 4'b0) begin
        n_fails++;
        $display("FAIL rstmid_quiet_%0d: got valid %0b busy %0b flush %0b%0b, required 0",
                 i, bus.redirect_valid, bus.busy, bus.flushA, bus.flushB);
      end
    end
    bus.br_validA = 1; bus.branch_takenA = 1; bus.targetA = 32'h7000;
    push_exp(1'b0, 32'h7000);
    tick();
    clear_inputs();
    wait_idle("rstmid");
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    test_reset();
    test_unified();
    test_no_effect();
    test_split_tie();
    test_backpressure();
    test_unified_b();
    test_reset_mid();
    tick();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL sb_leftover: got %0d redirects never issued, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/branch_redirect_ctrl.md
# branch_redirect_ctrl

- Downstream consumer of the branch decider's `branch_takenA`/`branch_takenB`.
- Turns taken-branch decisions into PC redirect requests to the fetch unit.
- Flushes younger work in the offending lane and stalls that lane until its redirect has been accepted and the pipeline has drained.
- Supports unified mode (lane A only) and split mode (independent lanes A and B that share one fetch redirect port).

## Interface
- XLEN, 32: PC/target width.
- DRAIN_CYCLES, 2: post-accept bubble cycles before the next redirect may issue; must be ≥1.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mode  in  1  1 = unified (lane A only), 0 = split. Changes only while busy=0.
- br_validA  in  1  lane A branch resolution valid this cycle.
- branch_takenA  in  1  lane A taken, from the branch decider.
- targetA  in  XLEN  lane A branch target.
- br_validB  in  1  lane B branch resolution valid this cycle.
- branch_takenB  in  1  lane B taken, from the branch decider.
- targetB  in  XLEN  lane B branch target.
- redirect_valid  out  1  redirect request to fetch.
- redirect_lane  out  1  0 = A, 1 = B.
- redirect_pc  out  XLEN  redirect target.
- redirect_ready  in  1  fetch accepts the redirect.
- flushA  out  1  one-cycle flush pulse, lane A.
- flushB  out  1  one-cycle flush pulse, lane B.
- stallA  out  1  lane A must hold new branch resolutions.
- stallB  out  1  lane B must hold new branch resolutions.
- busy  out  1  any pending redirect, or FSM not IDLE.

## Operation
- Capture on lane X: `br_validX & branch_takenX & ~stallX` at a rising edge.
  - Sets pendX and stores the target in pc_regX.
  - In unified mode lane B never captures, and pendB is forced to 0.
  - Captures while stallX=1 are ignored; upstream must hold until stallX=0.
  - Not-taken or invalid resolutions have no effect.
- flushX: registered. It is high for exactly the one cycle following the capture edge.
- stallX = pendX | (state≠IDLE & sel_lane==X).
- FSM states: IDLE, REQ, DRAIN.
  - IDLE: if any pend is set, go to REQ at the next edge and latch sel_lane.
    - Only one pend set: select that lane.
    - Both set: select the lane ≠ last_served (fairness).
  - REQ: redirect_valid=1, redirect_lane=sel_lane, redirect_pc=pc_reg[sel_lane].
    - All three outputs are held stable until handshake.
    - On the edge with redirect_valid & redirect_ready: clear pend[sel_lane], set last_served=sel_lane, load drain_cnt=DRAIN_CYCLES-1, go to DRAIN.
  - DRAIN: redirect_valid=0 and stall[sel_lane] stays 1.
    - Decrement each cycle.
    - At drain_cnt==0 go to IDLE. The next selection happens from IDLE (one more cycle).
- Simultaneous captures on A and B in the same edge are both accepted.
- A capture on lane X while lane Y is in REQ/DRAIN is accepted and queued in pendX.
- redirect_pc/redirect_lane read 0 when redirect_valid=0.

## Timing
- Reset values: state=IDLE, pendA=pendB=0, last_served=B (so A wins the first tie), drain_cnt=0. All outputs 0.
- Capture at edge T:
  - flushX=1 during cycle T..T+1.
  - stallX=1 from T.
  - redirect_valid=1 from edge T+1 when the FSM was IDLE.
- Redirect accepted at edge R:
  - stall[sel] deasserts after edge R+DRAIN_CYCLES.
  - The earliest next redirect_valid rises at edge R+DRAIN_CYCLES+1.
- Back-to-back A then B, both captured at T, ready held 1, DRAIN_CYCLES=2:
  - A valid T+1..T+2, accepted at T+2.
  - DRAIN for T+2..T+4.
  - B valid from T+5.
- Reset asserted mid-REQ/DRAIN: immediate return to reset values.
  - Pending redirects are lost.
  - No flush pulse is generated on reset exit.

## Test plan
- Unified, A takes a branch at T with targetA=0x0000_1000, ready=1:
  - flushA pulses once.
  - redirect_valid=1 lane 0 pc 0x1000 for one cycle at T+1.
  - stallA falls 2 cycles after accept.
  - busy=0 afterwards.
- Not taken (br_validA=1, branch_takenA=0), and taken with br_valid=0: no flush, no redirect, no stall, over 10 cycles.
- Split, A (0x100) and B (0x200) taken at the same edge:
  - Both flush pulses fire.
  - Redirect A is issued first, then B, separated by DRAIN_CYCLES+1 idle cycles.
  - last_served then makes the next tie go to A.
- Backpressure: ready=0 for 5 cycles during REQ, with B capturing meanwhile.
  - valid, lane and pc stay stable.
  - The accept happens on the first ready=1 edge.
  - B is queued and issued after A's drain.
- Unified mode with lane B toggling taken: flushB, stallB and redirect lane 1 never assert.
- rst_n dropped while in REQ with pendB set:
  - All outputs 0 immediately.
  - After release, no redirect issues until a new capture.
